// File: rtl/vx_credit_arb.sv
// Round-robin arbiter sharing one registered memory request port among NUM_REQS
// requesters, with per-requester credit limits and tag-based response routing.
module vx_credit_arb #(
  parameter  int NUM_REQS      = 4,
  parameter  int DATAW         = 64,
  parameter  int RSP_DATAW     = 32,
  parameter  int TAG_IN_WIDTH  = 8,
  parameter  int MAX_PENDING   = 4,
  localparam int LOG_NUM_REQS  = $clog2(NUM_REQS),
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS,
  localparam int CNTW          = $clog2(MAX_PENDING + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid_in,
  input  logic [NUM_REQS*DATAW-1:0]        req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
  output logic [NUM_REQS-1:0]              req_ready_in,
  output logic                             req_valid_out,
  output logic [DATAW-1:0]                 req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
  input  logic                             req_ready_out,
  input  logic                             rsp_valid_in,
  input  logic [RSP_DATAW-1:0]             rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in,
  output logic                             rsp_ready_in,
  output logic [NUM_REQS-1:0]              rsp_valid_out,
  output logic [RSP_DATAW-1:0]             rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]          rsp_tag_out,
  input  logic [NUM_REQS-1:0]              rsp_ready_out,
  output logic                             idle
);

  logic                               r_valid;
  logic [DATAW-1:0]                   r_data;
  logic [TAG_OUT_WIDTH-1:0]           r_tag;
  logic [LOG_NUM_REQS-1:0]            r_ptr;
  logic [NUM_REQS-1:0][CNTW-1:0]      r_pending;

  logic [NUM_REQS-1:0][CNTW-1:0]      w_pending_next;
  logic [DATAW-1:0]                   w_data_arr [NUM_REQS];
  logic [TAG_IN_WIDTH-1:0]            w_tag_arr  [NUM_REQS];
  logic [NUM_REQS-1:0]                w_eligible;
  logic [NUM_REQS-1:0]                w_busy;
  logic [NUM_REQS-1:0]                w_rsp_fire;
  logic                               w_load;
  logic                               w_found;
  logic                               w_accept;
  logic [LOG_NUM_REQS-1:0]            w_gnt_idx;
  logic [LOG_NUM_REQS:0]              w_cand;
  logic [LOG_NUM_REQS-1:0]            w_sel;
  logic                               w_sel_ok;

  // Search eligible requesters starting at r_ptr, wrapping modulo NUM_REQS.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_cand = {1'b0, r_ptr} + (LOG_NUM_REQS+1)'(k);
      if (w_cand >= (LOG_NUM_REQS+1)'(NUM_REQS))
        w_cand = w_cand - (LOG_NUM_REQS+1)'(NUM_REQS);
      if (!w_found && w_eligible[w_cand[LOG_NUM_REQS-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[LOG_NUM_REQS-1:0];
      end
    end
  end

  assign w_load   = !r_valid || req_ready_out;
  assign w_accept = w_load && w_found;

  assign w_sel    = rsp_tag_in[LOG_NUM_REQS-1:0];
  assign w_sel_ok = ({1'b0, w_sel} < (LOG_NUM_REQS+1)'(NUM_REQS));

  // Out-of-range selects are swallowed so the response port never stalls.
  assign rsp_ready_in = w_sel_ok ? rsp_ready_out[w_sel] : 1'b1;
  assign rsp_data_out = rsp_data_in;
  assign rsp_tag_out  = rsp_tag_in[TAG_OUT_WIDTH-1:LOG_NUM_REQS];

  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
      assign w_data_arr[gi]    = req_data_in[gi*DATAW +: DATAW];
      assign w_tag_arr[gi]     = req_tag_in[gi*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      assign w_eligible[gi]    = req_valid_in[gi] && (r_pending[gi] < CNTW'(MAX_PENDING));
      assign w_busy[gi]        = (r_pending[gi] != '0);
      assign req_ready_in[gi]  = w_accept && (w_gnt_idx == LOG_NUM_REQS'(gi));
      assign rsp_valid_out[gi] = rsp_valid_in && w_sel_ok && (w_sel == LOG_NUM_REQS'(gi));
      assign w_rsp_fire[gi]    = rsp_valid_out[gi] && rsp_ready_in;

      // Accept and response together cancel; a response at zero saturates.
      always_comb begin
        w_pending_next[gi] = r_pending[gi];
        if (req_ready_in[gi] && !w_rsp_fire[gi])
          w_pending_next[gi] = r_pending[gi] + CNTW'(1);
        else if (w_rsp_fire[gi] && !req_ready_in[gi] && w_busy[gi])
          w_pending_next[gi] = r_pending[gi] - CNTW'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_data <= w_data_arr[w_gnt_idx];
        r_tag  <= {w_tag_arr[w_gnt_idx], w_gnt_idx};
        r_ptr  <= (w_gnt_idx == LOG_NUM_REQS'(NUM_REQS-1)) ? '0 : w_gnt_idx + LOG_NUM_REQS'(1);
      end
    end
  end

  assign req_valid_out = r_valid;
  assign req_data_out  = r_data;
  assign req_tag_out   = r_tag;
  assign idle          = !r_valid && !(|w_busy);

endmodule
